udp_tx_packetizer: RTL and testbench

//  Application-to-UDP-core transmit path: accepts DATA_W-bit words from the app, buffers one datagram,

---
 rtl/udp_pkg.sv | 11 +
 rtl/udp_tx_buf_ram.sv | 20 ++
 rtl/udp_tx_packetizer.sv | 136 +++++++++++++
 tb/tb_udp_tx_packetizer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// udp_pkg: shared UDP constants, transmit FSM encoding and clog2 helper
package udp_pkg;
    localparam int UDP_HDR_BYTES = 8;
    typedef enum logic [1:0] {S_FILL = 2'd0, S_HDR = 2'd1, S_PAYLOAD = 2'd2} tx_state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
        return r;
    endfunction
endpackage

// File: rtl/udp_tx_buf_ram.sv
// udp_tx_buf_ram: simple dual-port datagram buffer with 1-cycle registered read
// Ports: clk; we/waddr/wdata write port; raddr read address, rdata = mem[raddr] one cycle later.
module udp_tx_buf_ram import udp_pkg::*; #(
    parameter int DATA_W = 64,
    parameter int DEPTH = 184,
    parameter int AW = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer: buffers one app datagram, then sends a UDP header and a byte-wide payload stream
// Ports: clk, rst_n (async, active-low); din_* app word input with ready/valid/last/bytes;
//        local_ip/dest_ip/local_port/dest_port config; tx_udp_hdr_* header handshake and fields;
//        tx_udp_payload_axis_* byte stream; tx_busy high unless idle with an empty buffer.
module udp_tx_packetizer import udp_pkg::*; #(
    parameter int DATA_W = 64,
    parameter int MAX_PAYLOAD = 1472,
    localparam int BPW = DATA_W / 8,
    localparam int BW = clog2(BPW + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din_data,
    input  logic [BW-1:0]     din_bytes,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              din_ready,
    input  logic [31:0]       local_ip,
    input  logic [31:0]       dest_ip,
    input  logic [15:0]       local_port,
    input  logic [15:0]       dest_port,
    output logic              tx_udp_hdr_valid,
    input  logic              tx_udp_hdr_ready,
    output logic [31:0]       tx_udp_ip_source_ip,
    output logic [31:0]       tx_udp_ip_dest_ip,
    output logic [15:0]       tx_udp_source_port,
    output logic [15:0]       tx_udp_dest_port,
    output logic [15:0]       tx_udp_length,
    output logic [7:0]        tx_udp_payload_axis_tdata,
    output logic              tx_udp_payload_axis_tvalid,
    input  logic              tx_udp_payload_axis_tready,
    output logic              tx_udp_payload_axis_tlast,
    output logic              tx_udp_payload_axis_tuser,
    output logic              tx_busy
);
    localparam int DEPTH = MAX_PAYLOAD / BPW;
    localparam int AW = DEPTH > 1 ? clog2(DEPTH) : 1;
    localparam int IW = BPW > 1 ? clog2(BPW) : 1;

    tx_state_t state, state_d;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_d;
    logic [15:0] byte_cnt, cnt_next, out_cnt;
    logic [IW-1:0] byte_idx;
    logic [DATA_W-1:0] pf_word, rdata;
    logic accept, fill_exit, load, beat, last_beat, word_end;

    assign accept = din_valid && din_ready;
    assign cnt_next = byte_cnt + ((din_last && din_bytes != '0) ? 16'(din_bytes) : 16'(BPW));
    assign fill_exit = accept && (din_last || cnt_next >= 16'(MAX_PAYLOAD));
    // first PAYLOAD cycle with no byte presented moves the prefetched word 0 into the output register
    assign load = state == S_PAYLOAD && !tx_udp_payload_axis_tvalid;
    assign beat = tx_udp_payload_axis_tvalid && tx_udp_payload_axis_tready;
    assign last_beat = beat && tx_udp_payload_axis_tlast;
    assign word_end = byte_idx == IW'(BPW - 1);
    // RAM address tracks the word after the one being shifted out, so rdata always holds it ready
    assign rd_ptr_d = state != S_PAYLOAD ? '0
                    : (load || (beat && !tx_udp_payload_axis_tlast && word_end)) ? rd_ptr + AW'(1) : rd_ptr;
    assign tx_udp_payload_axis_tlast = tx_udp_payload_axis_tvalid && out_cnt == byte_cnt - 16'd1;
    assign tx_udp_payload_axis_tdata = 8'(pf_word >> {byte_idx, 3'b000});
    assign tx_udp_payload_axis_tuser = 1'b0;

    udp_tx_buf_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk  (clk),
        .we   (accept),
        .waddr(wr_ptr),
        .wdata(din_data),
        .raddr(rd_ptr_d),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FILL;
        else state <= state_d;
    end

    always_comb begin
        state_d = state == S_FILL    ? (fill_exit ? S_HDR : S_FILL)
                : state == S_HDR     ? (tx_udp_hdr_ready ? S_PAYLOAD : S_HDR)
                : state == S_PAYLOAD ? (last_beat ? S_FILL : S_PAYLOAD)
                : S_FILL;
    end

    always_comb begin
        din_ready = state == S_FILL;
        tx_udp_hdr_valid = state == S_HDR;
        tx_busy = state != S_FILL || byte_cnt != '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            byte_cnt <= '0;
            out_cnt <= '0;
            byte_idx <= '0;
            pf_word <= '0;
            tx_udp_payload_axis_tvalid <= 1'b0;
            tx_udp_ip_source_ip <= '0;
            tx_udp_ip_dest_ip <= '0;
            tx_udp_source_port <= '0;
            tx_udp_dest_port <= '0;
            tx_udp_length <= '0;
        end else begin
            rd_ptr <= rd_ptr_d;
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
                byte_cnt <= cnt_next;
            end
            if (fill_exit) begin
                tx_udp_ip_source_ip <= local_ip;
                tx_udp_ip_dest_ip <= dest_ip;
                tx_udp_source_port <= local_port;
                tx_udp_dest_port <= dest_port;
                tx_udp_length <= cnt_next + 16'(UDP_HDR_BYTES);
            end
            if (load) begin
                pf_word <= rdata;
                tx_udp_payload_axis_tvalid <= 1'b1;
                byte_idx <= '0;
                out_cnt <= '0;
            end else if (beat) begin
                out_cnt <= out_cnt + 16'd1;
                if (tx_udp_payload_axis_tlast) begin
                    tx_udp_payload_axis_tvalid <= 1'b0;
                    wr_ptr <= '0;
                    byte_cnt <= '0;
                end else if (word_end) begin
                    pf_word <= rdata;
                    byte_idx <= '0;
                end else begin
                    byte_idx <= byte_idx + IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_udp_tx_packetizer.sv
// tb_udp_tx_packetizer: directed scenarios for the UDP transmit packetizer
module tb_udp_tx_packetizer;
    logic clk, rst_n;
    logic [63:0] din_data;
    logic [3:0] din_bytes;
    logic din_valid, din_last, din_ready;
    logic [31:0] local_ip, dest_ip, sip, dip;
    logic [15:0] local_port, dest_port, sport, dport, hlen;
    logic hdr_valid, hdr_ready;
    logic [7:0] p_tdata;
    logic p_tvalid, p_tready, p_tlast, p_tuser, tx_busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx [0:2047];
    logic [7:0] exp_q[$];
    int rx_n, rx_last, rx_lat, rx_stall_err, rx_dinrdy, rx_timeout;
    logic [15:0] rx_len, rx_sport, rx_dport;
    logic [31:0] rx_sip, rx_dip;

    udp_tx_packetizer dut (
        .clk(clk), .rst_n(rst_n),
        .din_data(din_data), .din_bytes(din_bytes), .din_valid(din_valid), .din_last(din_last),
        .din_ready(din_ready),
        .local_ip(local_ip), .dest_ip(dest_ip), .local_port(local_port), .dest_port(dest_port),
        .tx_udp_hdr_valid(hdr_valid), .tx_udp_hdr_ready(hdr_ready),
        .tx_udp_ip_source_ip(sip), .tx_udp_ip_dest_ip(dip),
        .tx_udp_source_port(sport), .tx_udp_dest_port(dport), .tx_udp_length(hlen),
        .tx_udp_payload_axis_tdata(p_tdata), .tx_udp_payload_axis_tvalid(p_tvalid),
        .tx_udp_payload_axis_tready(p_tready), .tx_udp_payload_axis_tlast(p_tlast),
        .tx_udp_payload_axis_tuser(p_tuser), .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mkword(input int b);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(b + k);
        return w;
    endfunction

    function automatic int drain_bytes(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0 || i >= 2048 || rx[i] !== exp_q[0]) bad++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        return bad;
    endfunction

    task automatic push(input logic [63:0] d, input logic [3:0] nb, input logic l);
        int t;
        t = 0;
        din_data = d; din_bytes = nb; din_last = l; din_valid = 1'b1;
        while (!din_ready && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) begin
            checks++; errors++;
            $display("FAIL push_timeout din_ready=%0b after %0d cycles, required 1", din_ready, t);
        end
        @(negedge clk);
        din_valid = 1'b0; din_last = 1'b0;
        if (t < 5000)
            for (int k = 0; k < ((l && nb != 0) ? int'(nb) : 8); k++) exp_q.push_back(d[8*k +: 8]);
    endtask

    task automatic recv(input int hdr_delay, input bit toggle);
        int t;
        logic r, stalled, done;
        logic [7:0] pd;
        rx_n = 0; rx_last = -1; rx_lat = 0; rx_stall_err = 0; rx_dinrdy = 0; rx_timeout = 0;
        hdr_ready = 1'b0; p_tready = 1'b0; t = 0;
        while (!hdr_valid && t < 3000) begin @(negedge clk); t++; end
        if (t >= 3000) rx_timeout = 1;
        rx_len = hlen; rx_sip = sip; rx_dip = dip; rx_sport = sport; rx_dport = dport;
        repeat (hdr_delay) @(negedge clk);
        hdr_ready = 1'b1;
        @(negedge clk);
        hdr_ready = 1'b0;
        t = 0;
        while (!p_tvalid && t < 20) begin @(negedge clk); t++; end
        rx_lat = t + 1;
        stalled = 1'b0; pd = '0; done = 1'b0; t = 0;
        while (!done && t < 6000) begin
            if (din_ready) rx_dinrdy++;
            if (stalled && (!p_tvalid || p_tdata !== pd)) rx_stall_err++;
            r = toggle ? (t % 2 == 0) : 1'b1;
            p_tready = r;
            if (p_tvalid && r) begin
                if (rx_n < 2048) rx[rx_n] = p_tdata;
                if (p_tlast) begin rx_last = rx_n; done = 1'b1; end
                rx_n++;
            end
            stalled = p_tvalid && !r;
            pd = p_tdata;
            @(negedge clk);
            t++;
        end
        if (!done) rx_timeout = 1;
        p_tready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rst_din_ready got %b exp 1", din_ready); end
        checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL rst_hdr_valid got %b exp 0", hdr_valid); end
        checks++; if (p_tvalid !== 1'b0 || p_tlast !== 1'b0) begin errors++; $display("FAIL rst_tvalid_tlast got %b%b exp 00", p_tvalid, p_tlast); end
        checks++; if (hlen !== 16'd0) begin errors++; $display("FAIL rst_length got %0d exp 0", hlen); end
        checks++; if (sip !== 32'd0 || sport !== 16'd0) begin errors++; $display("FAIL rst_fields got %h %h exp 0", sip, sport); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", tx_busy); end
        checks++; if (p_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser got %b exp 0", p_tuser); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multi_word();
        int bad;
        push(mkword(8'h10), 4'd0, 1'b0);
        push(mkword(8'h18), 4'd0, 1'b0);
        push(mkword(8'h20), 4'd5, 1'b1);
        recv(0, 1'b0);
        bad = drain_bytes(rx_n);
        checks++; if (rx_len !== 16'd29) begin errors++; $display("FAIL t1_length got %0d exp 29", rx_len); end
        checks++; if (rx_timeout != 0 || rx_n != 21) begin errors++; $display("FAIL t1_count got %0d exp 21 (timeout %0d)", rx_n, rx_timeout); end
        checks++; if (rx_last != 20) begin errors++; $display("FAIL t1_tlast_pos got %0d exp 20", rx_last); end
        checks++; if (bad != 0) begin errors++; $display("FAIL t1_bytes got %0d bad exp 0", bad); end
        checks++; if (rx[0] !== 8'h10 || rx[20] !== 8'h24) begin errors++; $display("FAIL t1_ends got %h %h exp 10 24", rx[0], rx[20]); end
        checks++; if (rx_lat != 2) begin errors++; $display("FAIL t1_latency got %0d exp 2", rx_lat); end
        checks++; if (rx_sip !== 32'hC0A80001 || rx_dip !== 32'hC0A80002) begin errors++; $display("FAIL t1_ips got %h %h exp c0a80001 c0a80002", rx_sip, rx_dip); end
        checks++; if (rx_sport !== 16'd1234 || rx_dport !== 16'd5678) begin errors++; $display("FAIL t1_ports got %0d %0d exp 1234 5678", rx_sport, rx_dport); end
        checks++; if (rx_dinrdy != 0) begin errors++; $display("FAIL t1_din_ready_in_tx got %0d exp 0", rx_dinrdy); end
        checks++; if (din_ready !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL t1_idle got rdy %b busy %b exp 1 0", din_ready, tx_busy); end
    endtask

    task automatic test_full_word_last();
        int bad;
        push(mkword(8'h40), 4'd0, 1'b1);
        recv(3, 1'b0);
        bad = drain_bytes(rx_n);
        checks++; if (rx_len !== 16'd16) begin errors++; $display("FAIL t2_length got %0d exp 16", rx_len); end
        checks++; if (rx_timeout != 0 || rx_n != 8) begin errors++; $display("FAIL t2_count got %0d exp 8", rx_n); end
        checks++; if (rx_last != 7) begin errors++; $display("FAIL t2_tlast_pos got %0d exp 7", rx_last); end
        checks++; if (bad != 0 || rx[7] !== 8'h47) begin errors++; $display("FAIL t2_bytes got %0d bad last %h exp 0 47", bad, rx[7]); end
    endtask

    task automatic test_auto_split();
        int bad;
        fork
            begin
                for (int n = 0; n < 200; n++) push(mkword(n * 8), 4'd0, 1'b0);
            end
            recv(0, 1'b0);
        join
        bad = drain_bytes(rx_n);
        checks++; if (rx_len !== 16'd1480) begin errors++; $display("FAIL t3_length got %0d exp 1480", rx_len); end
        checks++; if (rx_timeout != 0 || rx_n != 1472) begin errors++; $display("FAIL t3_count got %0d exp 1472", rx_n); end
        checks++; if (rx_last != 1471 || rx[1471] !== 8'hBF) begin errors++; $display("FAIL t3_tlast got pos %0d byte %h exp 1471 bf", rx_last, rx[1471]); end
        checks++; if (bad != 0) begin errors++; $display("FAIL t3_bytes got %0d bad exp 0", bad); end
        checks++; if (rx_dinrdy != 0) begin errors++; $display("FAIL t3_din_ready_in_tx got %0d exp 0", rx_dinrdy); end
        checks++; if (hdr_valid !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL t3_buffered got hv %b busy %b exp 0 1", hdr_valid, tx_busy); end
        push(mkword(200 * 8), 4'd0, 1'b1);
        recv(0, 1'b0);
        bad = drain_bytes(rx_n);
        checks++; if (rx_len !== 16'd144) begin errors++; $display("FAIL t3b_length got %0d exp 144", rx_len); end
        checks++; if (rx_n != 136 || rx_last != 135) begin errors++; $display("FAIL t3b_count got %0d last %0d exp 136 135", rx_n, rx_last); end
        checks++; if (bad != 0 || rx[0] !== 8'hC0) begin errors++; $display("FAIL t3b_bytes got %0d bad first %h exp 0 c0", bad, rx[0]); end
    endtask

    task automatic test_hdr_hold();
        logic [15:0] old;
        int bad, bbad;
        push(mkword(8'h60), 4'd3, 1'b1);
        old = local_port;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) local_port = 16'hBEEF;
            if (!hdr_valid || sport !== old || hlen !== 16'd11 || p_tvalid) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL t4_hold got %0d bad cycles exp 0", bad); end
        checks++; if (hdr_valid !== 1'b1 || sport !== old) begin errors++; $display("FAIL t4_after_wait got hv %b port %h exp 1 %h", hdr_valid, sport, old); end
        recv(0, 1'b0);
        bbad = drain_bytes(rx_n);
        checks++; if (rx_len !== 16'd11 || rx_sport !== old) begin errors++; $display("FAIL t4_hdr got len %0d port %h exp 11 %h", rx_len, rx_sport, old); end
        checks++; if (rx_n != 3 || rx_last != 2 || bbad != 0) begin errors++; $display("FAIL t4_payload got n %0d last %0d bad %0d exp 3 2 0", rx_n, rx_last, bbad); end
        local_port = 16'd1234;
    endtask

    task automatic test_backpressure();
        int bad;
        push(mkword(8'h80), 4'd0, 1'b0);
        push(mkword(8'h88), 4'd0, 1'b1);
        recv(1, 1'b1);
        bad = drain_bytes(rx_n);
        checks++; if (rx_stall_err != 0) begin errors++; $display("FAIL t5_stall got %0d violations exp 0", rx_stall_err); end
        checks++; if (rx_timeout != 0 || rx_n != 16 || rx_last != 15) begin errors++; $display("FAIL t5_count got %0d last %0d exp 16 15", rx_n, rx_last); end
        checks++; if (bad != 0 || rx[15] !== 8'h8F) begin errors++; $display("FAIL t5_bytes got %0d bad last %h exp 0 8f", bad, rx[15]); end
    endtask

    task automatic test_reset_mid_payload();
        int bad;
        push(mkword(8'h90), 4'd0, 1'b0);
        push(mkword(8'h98), 4'd0, 1'b0);
        push(mkword(8'hA0), 4'd0, 1'b1);
        hdr_ready = 1'b1;
        @(negedge clk);
        hdr_ready = 1'b0;
        p_tready = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (p_tvalid !== 1'b1) begin errors++; $display("FAIL t6_mid got tvalid %b exp 1", p_tvalid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (p_tvalid !== 1'b0 || hdr_valid !== 1'b0) begin errors++; $display("FAIL t6_async got tv %b hv %b exp 0 0", p_tvalid, hdr_valid); end
        p_tready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (din_ready !== 1'b1 || tx_busy !== 1'b0 || hlen !== 16'd0) begin errors++; $display("FAIL t6_release got rdy %b busy %b len %0d exp 1 0 0", din_ready, tx_busy, hlen); end
        push(mkword(8'hB0), 4'd4, 1'b1);
        recv(2, 1'b0);
        bad = drain_bytes(rx_n);
        checks++; if (rx_len !== 16'd12) begin errors++; $display("FAIL t6_length got %0d exp 12", rx_len); end
        checks++; if (rx_n != 4 || rx_last != 3 || bad != 0 || rx[0] !== 8'hB0) begin errors++; $display("FAIL t6_frame got n %0d last %0d bad %0d first %h exp 4 3 0 b0", rx_n, rx_last, bad, rx[0]); end
    endtask

    initial begin
        rst_n = 1'b0;
        din_data = '0; din_bytes = '0; din_valid = 1'b0; din_last = 1'b0;
        hdr_ready = 1'b0; p_tready = 1'b0;
        local_ip = 32'hC0A80001; dest_ip = 32'hC0A80002;
        local_port = 16'd1234; dest_port = 16'd5678;
        test_reset();
        test_multi_word();
        test_full_word_last();
        test_auto_split();
        test_hdr_hold();
        test_backpressure();
        test_reset_mid_payload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
